clkdiv_multi: RTL and testbench

Parametrised multi-channel clock divider, successor to the single fixed-ratio divider. It generates CH independent divided clocks from one system clock. Each channel has its own runtime-programmable divisor, an enable, and a single-cycle tick strobe. The block feeds the microprocessor's slow-clock consumers (CPU step clock, display scan, debounce) from one place.

---
 rtl/clkdiv_multi_if.sv | 35 +++
 rtl/clkdiv_multi.sv | 80 ++++++++
 tb/tb_clkdiv_multi.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi_if - control and output bundle for the multi-channel clock divider.
//
// Carries everything except the system clock and reset:
//   en      [CH]  per-channel run enable
//   wr_en         divisor write strobe (one cycle)
//   wr_ch   [4]   channel index for the write
//   wr_div  [CW]  new divisor value
//   sync          (only with CLKDIV_SYNC_EN) restart every channel in phase
//   clkout  [CH]  divided clocks
//   tick    [CH]  one-cycle strobe in the cycle each clkout bit toggles
//
// The master modport is the controlling side (testbench or CPU glue), the
// slave modport is the divider itself.
interface clkdiv_multi_if #(
  parameter int CH = 4,
  parameter int CW = 32
);
  logic [CH-1:0] en;
  logic          wr_en;
  logic [3:0]    wr_ch;
  logic [CW-1:0] wr_div;
`ifdef CLKDIV_SYNC_EN
  logic          sync;
`endif
  logic [CH-1:0] clkout;
  logic [CH-1:0] tick;

`ifdef CLKDIV_SYNC_EN
  modport master (output en, wr_en, wr_ch, wr_div, sync, input clkout, tick);
  modport slave  (input en, wr_en, wr_ch, wr_div, sync, output clkout, tick);
`else
  modport master (output en, wr_en, wr_ch, wr_div, input clkout, tick);
  modport slave  (input en, wr_en, wr_ch, wr_div, output clkout, tick);
`endif
endinterface

// File: rtl/clkdiv_multi.sv
// clkdiv_multi - CH independent clock dividers running from one system clock.
//
// Each channel counts 0..div and toggles its output when the count equals
// the divisor, giving a 50 % duty clock of period 2*(div+1) clkin cycles,
// plus a one-cycle tick in the cycle the output changes level.
//
// Ports:
//   clkin  system clock, all state changes on its rising edge
//   clr    asynchronous active-low reset (release synchronously to clkin)
//   bus    clkdiv_multi_if.slave: en, wr_en, wr_ch, wr_div, [sync], clkout, tick
//
// Optional feature: define CLKDIV_SYNC_EN to add bus.sync, which restarts
// every channel (cnt=0, clkout=0, tick=0) so equal-divisor channels line up.
module clkdiv_multi #(
  parameter int            CH          = 4,
  parameter int            CW          = 32,
  parameter logic [CW-1:0] DEFAULT_DIV = 25000000
) (
  input  logic               clkin,
  input  logic               clr,
  clkdiv_multi_if.slave      bus
);

  logic [CW-1:0] div_q [CH];
  logic [CW-1:0] cnt_q [CH];
  logic [CH-1:0] clkout_q;
  logic [CH-1:0] tick_q;
  logic          sync_now;

`ifdef CLKDIV_SYNC_EN
  assign sync_now = bus.sync;
`else
  assign sync_now = 1'b0;
`endif

  // Per-channel divider. Priority: sync > disable > write > terminal count
  // > increment. A write with an out-of-range index matches no channel, so
  // it falls through with no effect. A write to a disabled channel still
  // loads the divisor so software can program channels before enabling them.
  always_ff @(posedge clkin or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < CH; i++) begin
        div_q[i] <= DEFAULT_DIV;
        cnt_q[i] <= '0;
      end
      clkout_q <= '0;
      tick_q   <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sync_now) begin
          cnt_q[i]    <= '0;
          clkout_q[i] <= 1'b0;
          tick_q[i]   <= 1'b0;
        end else if (!bus.en[i]) begin
          cnt_q[i]    <= '0;
          clkout_q[i] <= 1'b0;
          tick_q[i]   <= 1'b0;
          if (bus.wr_en && (int'(bus.wr_ch) == i))
            div_q[i] <= bus.wr_div;
        end else if (bus.wr_en && (int'(bus.wr_ch) == i)) begin
          // clkout holds its level; the new period starts from this edge
          div_q[i]  <= bus.wr_div;
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b0;
        end else if (cnt_q[i] == div_q[i]) begin
          cnt_q[i]    <= '0;
          clkout_q[i] <= ~clkout_q[i];
          tick_q[i]   <= 1'b1;
        end else begin
          cnt_q[i]  <= cnt_q[i] + CW'(1);
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.clkout = clkout_q;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi - self-checking bench for clkdiv_multi (CH=4, CW=8,
// DEFAULT_DIV=3). Inputs are driven on the falling edge; the reference model
// keeps, per channel, the number of enabled edges left until the next toggle,
// and outputs are compared 1 time unit after each rising edge.
// Define CLKDIV_SYNC_EN to also exercise the sync input.
module tb_clkdiv_multi;
  localparam int NCH = 4;
  localparam int NCW = 8;
  localparam int DEF = 3;

  logic clkin = 1'b0;
  logic clr   = 1'b0;

  clkdiv_multi_if #(.CH(NCH), .CW(NCW)) bus ();

  clkdiv_multi #(.CH(NCH), .CW(NCW), .DEFAULT_DIV(NCW'(DEF))) dut (
    .clkin (clkin),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  int tests_run    = 0;
  int tests_failed = 0;

  // values to apply at the next falling edge
  logic [NCH-1:0] drv_en     = '0;
  logic           drv_wr_en  = 1'b0;
  logic [3:0]     drv_wr_ch  = '0;
  logic [NCW-1:0] drv_wr_div = '0;
  logic           drv_sync   = 1'b0;
  logic           drv_clr    = 1'b0;

  // reference model: divisor, edges remaining until toggle, output levels
  int unsigned m_div  [NCH];
  int unsigned m_rem  [NCH];
  bit          m_clk  [NCH];
  bit          m_tick [NCH];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]  = DEF;
      m_rem[i]  = DEF + 1;
      m_clk[i]  = 1'b0;
      m_tick[i] = 1'b0;
    end
  endtask

  // One rising edge worth of behaviour, from the currently driven inputs.
  task automatic modelStep();
    for (int i = 0; i < NCH; i++) begin
      bit wr;
      wr = drv_wr_en && (int'(drv_wr_ch) == i);
      if (!drv_clr) begin
        m_div[i] = DEF; m_rem[i] = DEF + 1; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
      end else if (drv_sync) begin
        m_rem[i] = m_div[i] + 1; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
      end else if (!drv_en[i]) begin
        if (wr) m_div[i] = int'(drv_wr_div);
        m_rem[i] = m_div[i] + 1; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
      end else if (wr) begin
        m_div[i] = int'(drv_wr_div); m_rem[i] = m_div[i] + 1; m_tick[i] = 1'b0;
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_clk[i]  = ~m_clk[i];
          m_tick[i] = 1'b1;
          m_rem[i]  = m_div[i] + 1;
        end else begin
          m_tick[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compareAll(input string tag);
    logic [NCH-1:0] exp_clk, exp_tick;
    for (int i = 0; i < NCH; i++) begin
      exp_clk[i]  = m_clk[i];
      exp_tick[i] = m_tick[i];
    end
    checkOutput({tag, ".clkout"}, 32'(bus.clkout), 32'(exp_clk));
    checkOutput({tag, ".tick"},   32'(bus.tick),   32'(exp_tick));
  endtask

  // Drive the staged inputs at the falling edge, advance the model across the
  // following rising edge and compare just after it.
  task automatic applyStimulus(input string tag);
    @(negedge clkin);
    bus.en     = drv_en;
    bus.wr_en  = drv_wr_en;
    bus.wr_ch  = drv_wr_ch;
    bus.wr_div = drv_wr_div;
`ifdef CLKDIV_SYNC_EN
    bus.sync   = drv_sync;
`endif
    clr = drv_clr;
    modelStep();
    @(posedge clkin);
    #1;
    compareAll(tag);
  endtask

  task automatic writeDiv(input int ch, input int dv, input string tag);
    drv_wr_en = 1'b1; drv_wr_ch = 4'(ch); drv_wr_div = NCW'(dv);
    applyStimulus(tag);
    drv_wr_en = 1'b0;
  endtask

  // Pull clr low between edges and confirm the outputs clear without a clock.
  task automatic asyncReset(input string tag);
    #2;
    clr = 1'b0; drv_clr = 1'b0;
    #1;
    modelReset();
    compareAll(tag);
    for (int k = 0; k < 3; k++) applyStimulus(tag);
    drv_clr = 1'b1;
  endtask

  initial begin
    bus.en = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    bus.sync = 1'b0;
`endif
    modelReset();
    #12;
    compareAll("reset");
    applyStimulus("reset_hold");
    drv_clr = 1'b1;

    // default divisor on channel 0 only
    drv_en = 4'b0001;
    for (int k = 0; k < 20; k++) applyStimulus("ch0_default");

    // divide-by-2 on channel 1
    writeDiv(1, 0, "ch1_wr");
    drv_en = 4'b0011;
    for (int k = 0; k < 8; k++) applyStimulus("ch1_div0");

    // write coinciding with terminal count on channel 2
    writeDiv(2, 5, "ch2_wr5");
    drv_en = 4'b0111;
    for (int k = 0; k < 20 && m_rem[2] != 1; k++) applyStimulus("ch2_run");
    checkOutput("ch2_at_tc", m_rem[2], 1);
    writeDiv(2, 1, "ch2_wr_tc");
    for (int k = 0; k < 8; k++) applyStimulus("ch2_div1");

    // out-of-range channel index
    writeDiv(7, 0, "wr_ch7");
    for (int k = 0; k < 8; k++) applyStimulus("after_ch7");

    // drop channel 0 mid-period, then asynchronous reset mid-period
    drv_en = 4'b0110;
    for (int k = 0; k < 3; k++) applyStimulus("ch0_off");
    asyncReset("clr_async");
    drv_en = 4'b1111;
    for (int k = 0; k < 10; k++) applyStimulus("post_clr");

`ifdef CLKDIV_SYNC_EN
    drv_en = 4'b1001;
    writeDiv(0, 2, "sync_wr0");
    applyStimulus("sync_gap");
    writeDiv(3, 2, "sync_wr3");
    for (int k = 0; k < 5; k++) applyStimulus("sync_pre");
    drv_sync = 1'b1; drv_wr_en = 1'b1; drv_wr_ch = 4'd0; drv_wr_div = NCW'(5);
    applyStimulus("sync_pulse");
    drv_sync = 1'b0; drv_wr_en = 1'b0;
    for (int k = 0; k < 12; k++) applyStimulus("sync_post");
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(15) == 0) drv_en[$urandom_range(NCH-1)] ^= 1'b1;
      drv_wr_en  = ($urandom_range(5) == 0);
      drv_wr_ch  = 4'($urandom_range(7));
      drv_wr_div = NCW'($urandom_range(6));
`ifdef CLKDIV_SYNC_EN
      drv_sync   = ($urandom_range(39) == 0);
`endif
      applyStimulus("random");
      if (n == 200 || n == 400) asyncReset("random_clr");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
